uart_link_ctrl: RTL and testbench

- Bus-master sequencer for one uart_encode instance.
- Accepts byte-level TX/RX commands from a client and issues the register access sequence on uart_encode's sel/enable/addr[11:2] bus: baud (addr 4), mode (addr 2), then data (addr 0).
- Holds the data access until uart ready, then returns a response.
- Caches the last programmed baud and mode so redundant register writes are skipped.

---
 rtl/uart_link_pkg.sv | 37 +++
 rtl/uart_link_wr_seq.sv | 38 +++
 rtl/uart_link_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_link_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared constants, FSM state encoding and bus-phase encoding for the
// uart_link_ctrl sequencer and its write engine.
package uart_link_pkg;

  localparam logic [9:0] ADDR_DATA = 10'd0;
  localparam logic [9:0] ADDR_MODE = 10'd2;
  localparam logic [9:0] ADDR_BAUD = 10'd4;

  localparam logic [1:0] MODE_TX = 2'd1;
  localparam logic [1:0] MODE_RX = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BAUD_SU,
    ST_BAUD_AC,
    ST_BAUD_GAP,
    ST_MODE_SU,
    ST_MODE_AC,
    ST_MODE_GAP,
    ST_XFER_SU,
    ST_XFER_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SETUP,
    WR_ACCESS,
    WR_GAP
  } wr_phase_t;

  // Mode register value for a command direction (0 = TX, 1 = RX).
  function automatic logic [1:0] mode_for_dir(input logic dir);
    return dir ? MODE_RX : MODE_TX;
  endfunction

endpackage

// File: rtl/uart_link_wr_seq.sv
// Bus phase driver for uart_encode: turns a SETUP/ACCESS/GAP phase plus an
// address/data pair into sel/enable/addr/wdata. Shared by the baud, mode and
// data accesses; GAP and IDLE both park the bus at all-zero.
module uart_link_wr_seq
  import uart_link_pkg::*;
(
  input  wr_phase_t   i_phase,
  input  logic [9:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_sel,
  output logic        o_enable,
  output logic [9:0]  o_addr,
  output logic [31:0] o_wdata
);

  // Decode the current bus phase into the access signals.
  always_comb begin
    o_sel    = 1'b0;
    o_enable = 1'b0;
    o_addr   = '0;
    o_wdata  = '0;
    case (i_phase)
      WR_SETUP: begin
        o_sel   = 1'b1;
        o_addr  = i_addr;
        o_wdata = i_wdata;
      end
      WR_ACCESS: begin
        o_sel    = 1'b1;
        o_enable = 1'b1;
        o_addr   = i_addr;
        o_wdata  = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_link_ctrl.sv
// Bus-master sequencer for one uart_encode: programs baud (addr 4) and mode
// (addr 2) only when they differ from the cached values, then performs the
// data access (addr 0) and holds it until uart ready.
// Optional: define UART_LINK_TIMEOUT_EN to bound the wait for ready to
// TIMEOUT_CYC cycles, reporting rsp_err and invalidating the caches.
module uart_link_ctrl
  import uart_link_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned BAUD_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [BAUD_W-1:0] cmd_baud,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              m_sel,
  output logic              m_enable,
  output logic [9:0]        m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready
);

  state_t            r_state;
  state_t            w_next;
  logic              r_dir;
  logic [BAUD_W-1:0] r_baud;
  logic [DATA_W-1:0] r_data;
  logic              r_baud_vld;
  logic [BAUD_W-1:0] r_baud_q;
  logic              r_mode_vld;
  logic [1:0]        r_mode_q;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_timeout;
  logic [1:0]        w_mode;
  logic [1:0]        w_mode_cmd;
  wr_phase_t         w_phase;
  logic [9:0]        w_addr;
  logic [31:0]       w_wdata;
  logic              w_unused;

  assign w_accept   = cmd_valid && (r_state == ST_IDLE);
  assign w_mode     = mode_for_dir(r_dir);
  assign w_mode_cmd = mode_for_dir(cmd_dir);

  assign cmd_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_DONE);
  assign rsp_data   = rsp_valid ? r_rsp_data : '0;
  assign rsp_err    = rsp_valid && r_rsp_err;

`ifdef UART_LINK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0] r_to_cnt;

  // Wait-cycle counter: cleared on the way into XFER_WAIT, counts while there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_XFER_SU) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_XFER_WAIT) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_unused = ^m_rdata[31:DATA_W];
`else
  assign w_unused = ^{m_rdata[31:DATA_W], TIMEOUT_CYC == 0};
`endif

  // Next-state selection; zero baud short-circuits to DONE with no bus traffic.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_baud == '0)
            w_next = ST_DONE;
          else if (!r_baud_vld || (cmd_baud != r_baud_q))
            w_next = ST_BAUD_SU;
          else if (!r_mode_vld || (w_mode_cmd != r_mode_q))
            w_next = ST_MODE_SU;
          else
            w_next = ST_XFER_SU;
        end
      end
      ST_BAUD_SU:  w_next = ST_BAUD_AC;
      ST_BAUD_AC:  w_next = ST_BAUD_GAP;
      ST_BAUD_GAP: begin
        if (!r_mode_vld || (w_mode != r_mode_q))
          w_next = ST_MODE_SU;
        else
          w_next = ST_XFER_SU;
      end
      ST_MODE_SU:  w_next = ST_MODE_AC;
      ST_MODE_AC:  w_next = ST_MODE_GAP;
      ST_MODE_GAP: w_next = ST_XFER_SU;
      ST_XFER_SU:  w_next = ST_XFER_WAIT;
      ST_XFER_WAIT: begin
        if (m_ready) begin
          w_next = ST_DONE;
        end
`ifdef UART_LINK_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          w_next    = ST_DONE;
          w_timeout = 1'b1;
        end
`endif
      end
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Latch the command on the accepting handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir  <= 1'b0;
      r_baud <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_dir  <= cmd_dir;
      r_baud <= cmd_baud;
      r_data <= cmd_data;
    end
  end

  // Baud/mode caches: updated on the ACCESS cycle of each write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud_vld <= 1'b0;
      r_baud_q   <= '0;
      r_mode_vld <= 1'b0;
      r_mode_q   <= '0;
    end else begin
      if (r_state == ST_BAUD_AC) begin
        r_baud_vld <= 1'b1;
        r_baud_q   <= r_baud;
      end
      if (r_state == ST_MODE_AC) begin
        r_mode_vld <= 1'b1;
        r_mode_q   <= w_mode;
      end
`ifdef UART_LINK_TIMEOUT_EN
      if (w_timeout) begin
        r_baud_vld <= 1'b0;
        r_mode_vld <= 1'b0;
      end
`endif
    end
  end

  // Response payload: cleared per command, RX byte captured on the ready edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_rsp_data <= '0;
      r_rsp_err  <= (cmd_baud == '0);
    end else if ((r_state == ST_XFER_WAIT) && m_ready && r_dir) begin
      r_rsp_data <= m_rdata[DATA_W-1:0];
    end else if (w_timeout) begin
      r_rsp_err  <= 1'b1;
    end
  end

  // Map FSM state onto a bus phase and the address/data for that access.
  always_comb begin
    w_phase = WR_IDLE;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      ST_BAUD_SU, ST_BAUD_AC: begin
        w_phase = (r_state == ST_BAUD_SU) ? WR_SETUP : WR_ACCESS;
        w_addr  = ADDR_BAUD;
        w_wdata = 32'(r_baud);
      end
      ST_MODE_SU, ST_MODE_AC: begin
        w_phase = (r_state == ST_MODE_SU) ? WR_SETUP : WR_ACCESS;
        w_addr  = ADDR_MODE;
        w_wdata = 32'(w_mode);
      end
      ST_XFER_SU, ST_XFER_WAIT: begin
        w_phase = (r_state == ST_XFER_SU) ? WR_SETUP : WR_ACCESS;
        w_addr  = ADDR_DATA;
        w_wdata = r_dir ? 32'd0 : 32'(r_data);
      end
      ST_BAUD_GAP, ST_MODE_GAP: w_phase = WR_GAP;
      default: ;
    endcase
  end

  uart_link_wr_seq u_wr_seq (
    .i_phase  (w_phase),
    .i_addr   (w_addr),
    .i_wdata  (w_wdata),
    .o_sel    (m_sel),
    .o_enable (m_enable),
    .o_addr   (m_addr),
    .o_wdata  (m_wdata)
  );

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Scoreboard bench for uart_link_ctrl: expected bus accesses and responses are
// queued when a command is issued and checked as the DUT produces them.
module tb_uart_link_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BAUD_W = 16;
  localparam int unsigned TO_CYC = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [BAUD_W-1:0] cmd_baud;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              m_sel;
  logic              m_enable;
  logic [9:0]        m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;
  logic              m_ready;

  uart_link_ctrl #(
    .DATA_W      (DATA_W),
    .BAUD_W      (BAUD_W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_baud  (cmd_baud),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .m_sel     (m_sel),
    .m_enable  (m_enable),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        err;
    logic [7:0]  data;
    int unsigned lat;
  } rsp_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned hs_cyc   = 0;

  // Responder configuration for the current command.
  int          ready_delay = 0;
  bit          early       = 1'b0;
  bit          hold_low    = 1'b0;
  logic [31:0] rx_word     = '0;

  // Reference copy of the baud/mode caches.
  bit          mb_vld  = 1'b0;
  logic [15:0] mb_baud = '0;
  bit          mm_vld  = 1'b0;
  logic [1:0]  mm_mode = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // uart_encode stand-in: raises ready on the data access after a delay.
  initial begin : responder
    int cnt;
    cnt     = 0;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || rsp_valid) begin
        m_ready = 1'b0;
        cnt     = 0;
      end else if (!hold_low && !m_ready && m_sel && (m_addr == 10'd0) && (m_enable || early)) begin
        if (cnt >= ready_delay) begin
          m_ready = 1'b1;
          m_rdata = rx_word;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Bus monitor: checks each access against the queue and the phase shape.
  initial begin : bus_mon
    logic        prev_sel;
    logic        prev_en;
    logic [9:0]  prev_addr;
    logic [31:0] prev_wdata;
    bus_t        e;
    prev_sel = 1'b0; prev_en = 1'b0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sel = 1'b0;
        prev_en  = 1'b0;
      end else begin
        if (m_sel && m_enable && !prev_en) begin
          check_eq("setup_sel", prev_sel, 1'b1);
          check_eq("setup_addr_held", prev_addr, m_addr);
          check_eq("setup_wdata_held", prev_wdata, m_wdata);
          check_eq("bus_pending", exp_bus.size() != 0, 1'b1);
          if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            check_eq("bus_addr", m_addr, e.addr);
            check_eq("bus_wdata", m_wdata, e.wdata);
          end
        end
        if (prev_sel && prev_en && !m_sel) begin
          check_eq("gap_addr", m_addr, 10'd0);
          check_eq("gap_wdata", m_wdata, 32'd0);
        end
        prev_sel   = m_sel;
        prev_en    = m_enable;
        prev_addr  = m_addr;
        prev_wdata = m_wdata;
      end
    end
  end

  // Response monitor: payload, error flag and latency from the handshake.
  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        check_eq("rsp_pending", exp_rsp.size() != 0, 1'b1);
        if (exp_rsp.size() != 0) begin
          e = exp_rsp.pop_front();
          check_eq("rsp_err", rsp_err, e.err);
          check_eq("rsp_data", rsp_data, e.data);
          check_eq("rsp_latency", cyc_cnt - hs_cyc, e.lat);
        end
      end
    end
  end

  task automatic issue_cmd(input bit dir, input logic [15:0] baud, input logic [7:0] data,
                           input int dly, input bit erly, input bit hold,
                           input logic [31:0] rxw, input bit want_rsp);
    int unsigned misses;
    rsp_t        r;
    bus_t        b;
    logic [1:0]  mode;
    logic [9:0]  first_addr;
    bit          first_sel;
    bit          got_first;
    ready_delay = dly;
    early       = erly;
    hold_low    = hold;
    rx_word     = rxw;
    misses      = 0;
    first_sel   = 1'b0;
    first_addr  = '0;
    got_first   = 1'b0;
    r.err = 1'b0; r.data = '0; r.lat = 0;
    if (baud == 16'd0) begin
      r.err = 1'b1;
    end else begin
      first_sel = 1'b1;
      mode = dir ? 2'd2 : 2'd1;
      if (!mb_vld || baud != mb_baud) begin
        b.addr = 10'd4; b.wdata = 32'(baud); exp_bus.push_back(b);
        mb_vld = 1'b1; mb_baud = baud; misses++;
        first_addr = 10'd4; got_first = 1'b1;
      end
      if (!mm_vld || mode != mm_mode) begin
        b.addr = 10'd2; b.wdata = 32'(mode); exp_bus.push_back(b);
        mm_vld = 1'b1; mm_mode = mode; misses++;
        if (!got_first) begin first_addr = 10'd2; got_first = 1'b1; end
      end
      b.addr = 10'd0; b.wdata = dir ? 32'd0 : 32'(data); exp_bus.push_back(b);
      r.lat = 2 + 3 * misses + dly;
`ifdef UART_LINK_TIMEOUT_EN
      if (hold) begin
        r.err  = 1'b1;
        r.lat  = 2 + 3 * misses + TO_CYC - 1;
        mb_vld = 1'b0;
        mm_vld = 1'b0;
      end else begin
        r.data = dir ? rxw[7:0] : 8'd0;
      end
`else
      r.data = dir ? rxw[7:0] : 8'd0;
`endif
    end
    if (want_rsp) exp_rsp.push_back(r);
    check_eq("ready_before_cmd", cmd_ready, 1'b1);
    cmd_dir   = dir;
    cmd_baud  = baud;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc    = cyc_cnt;
    cmd_valid = 1'b0;
    check_eq("first_sel", m_sel, first_sel);
    check_eq("first_enable", m_enable, 1'b0);
    check_eq("first_addr", m_addr, first_addr);
    check_eq("busy_not_ready", cmd_ready, 1'b0);
  endtask

  task automatic wait_rsp(input int budget);
    for (int i = 0; i < budget && exp_rsp.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("rsp_outstanding", exp_rsp.size(), 0);
    exp_rsp.delete();
    @(negedge clk);
    #1;
    check_eq("rsp_one_cycle", rsp_valid, 1'b0);
    check_eq("ready_after_done", cmd_ready, 1'b1);
  endtask

  initial begin : main
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_baud  = '0;
    cmd_data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_sel", m_sel, 1'b0);
    check_eq("rst_enable", m_enable, 1'b0);
    check_eq("rst_addr", m_addr, 10'd0);
    check_eq("rst_wdata", m_wdata, 32'd0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_data", rsp_data, 8'd0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);

    // Cold TX: baud and mode both miss, ready after 200 cycles.
    issue_cmd(1'b0, 16'd20, 8'd101, 200, 1'b0, 1'b0, 32'hDEAD_BE55, 1'b1);
    wait_rsp(400);
    // RX at new baud: both miss again; only the low byte of m_rdata returns.
    issue_cmd(1'b1, 16'd40, 8'h00, 5, 1'b0, 1'b0, 32'hABCD_0040, 1'b1);
    wait_rsp(100);
    // Repeat RX: both caches hit.
    issue_cmd(1'b1, 16'd40, 8'h00, 0, 1'b0, 1'b0, 32'h0000_0099, 1'b1);
    wait_rsp(100);
    // Ready already high during XFER_SU.
    issue_cmd(1'b1, 16'd40, 8'h00, 0, 1'b1, 1'b0, 32'h1234_567F, 1'b1);
    wait_rsp(100);
    // Direction change only: mode miss.
    issue_cmd(1'b0, 16'd40, 8'hFF, 3, 1'b0, 1'b0, 32'h0000_00AA, 1'b1);
    wait_rsp(100);
    // Zero baud: error, no bus traffic, caches untouched.
    issue_cmd(1'b0, 16'd0, 8'h77, 0, 1'b0, 1'b0, 32'h0, 1'b1);
    wait_rsp(20);
    issue_cmd(1'b0, 16'd40, 8'h5A, 1, 1'b0, 1'b0, 32'h0, 1'b1);
    wait_rsp(100);
    // Largest divisor.
    issue_cmd(1'b0, 16'hFFFF, 8'hA5, 2, 1'b0, 1'b0, 32'h0, 1'b1);
    wait_rsp(100);

`ifdef UART_LINK_TIMEOUT_EN
    // Ready never arrives: timeout error, then full reprogram.
    issue_cmd(1'b0, 16'hFFFF, 8'h3C, 0, 1'b0, 1'b1, 32'h0, 1'b1);
    wait_rsp(100);
    issue_cmd(1'b0, 16'hFFFF, 8'h3C, 2, 1'b0, 1'b0, 32'h0, 1'b1);
    wait_rsp(100);
`endif

    // Reset in the middle of XFER_WAIT.
    issue_cmd(1'b1, 16'd55, 8'h00, 0, 1'b0, 1'b1, 32'h11, 1'b0);
    for (int i = 0; i < 60 && !(m_sel && m_enable && m_addr == 10'd0); i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("reached_xfer_wait", m_sel && m_enable, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_sel", m_sel, 1'b0);
    check_eq("abort_enable", m_enable, 1'b0);
    check_eq("abort_rsp_valid", rsp_valid, 1'b0);
    check_eq("abort_cmd_ready", cmd_ready, 1'b1);
    mb_vld   = 1'b0;
    mm_vld   = 1'b0;
    hold_low = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    issue_cmd(1'b1, 16'd55, 8'h00, 4, 1'b0, 1'b0, 32'h0000_0081, 1'b1);
    wait_rsp(100);

    check_eq("bus_leftover", exp_bus.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
